// File: rtl/spec_ghr_shiftreg_pkg.sv
`default_nettype none
// =============================================================================
// Module      : ghr_pkg
// Description : Shared types, defaults and helper function for the speculative
//               global-history shift register and its checkpoint FIFO.
// Contents    : GHR_HIST_LEN_DEF / GHR_CKPT_DEPTH_DEF default parameters,
//               ghr_prio_e next-state select, shift_in() history shifter.
// Revision    : 1.0 - initial release
// =============================================================================
package ghr_pkg;

    localparam int GHR_HIST_LEN_DEF   = 8;
    localparam int GHR_CKPT_DEPTH_DEF = 4;

    // Widest history shift_in() handles; callers size-cast in and out so a
    // single non-parametrised function serves every HIST_LEN up to this.
    localparam int GHR_HIST_MAX = 64;

    // Which source wins the next speculative-history value this cycle.
    typedef enum logic [1:0] {
        PRIO_NONE  = 2'd0,
        PRIO_PRED  = 2'd1,
        PRIO_MISP  = 2'd2,
        PRIO_FLUSH = 2'd3
    } ghr_prio_e;

    // Shift a new direction into the newest position (bit 0).
    function automatic logic [GHR_HIST_MAX-1:0] shift_in(
        input logic [GHR_HIST_MAX-1:0] hist,
        input logic                    new_bit
    );
        return {hist[GHR_HIST_MAX-2:0], new_bit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spec_ghr_shiftreg_if.sv
`default_nettype none
// =============================================================================
// Module      : spec_ghr_shiftreg_if
// Description : Predict / resolve / flush bus and history outputs of the
//               speculative GHR. master = front end, slave = GHR block.
// Signals     : pred_valid, pred_taken, pred_ready, resolve_valid,
//               resolve_taken, resolve_mispredict, flush, spec_hist,
//               commit_hist, inflight, resolve_err, and mispredict_cnt when
//               SPEC_GHR_STATS_EN is defined.
// Revision    : 1.0 - initial release
// =============================================================================
interface spec_ghr_shiftreg_if
    import ghr_pkg::*;
#(
    parameter int HIST_LEN   = GHR_HIST_LEN_DEF,
    parameter int CKPT_DEPTH = GHR_CKPT_DEPTH_DEF
) ();

    logic                            pred_valid;
    logic                            pred_taken;
    logic                            pred_ready;
    logic                            resolve_valid;
    logic                            resolve_taken;
    logic                            resolve_mispredict;
    logic                            flush;
    logic [HIST_LEN-1:0]             spec_hist;
    logic [HIST_LEN-1:0]             commit_hist;
    logic [$clog2(CKPT_DEPTH+1)-1:0] inflight;
    logic                            resolve_err;
`ifdef SPEC_GHR_STATS_EN
    logic [15:0]                     mispredict_cnt;

    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_taken,
               resolve_mispredict, flush,
        input  pred_ready, spec_hist, commit_hist, inflight, resolve_err,
               mispredict_cnt
    );

    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_taken,
               resolve_mispredict, flush,
        output pred_ready, spec_hist, commit_hist, inflight, resolve_err,
               mispredict_cnt
    );
`else
    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_taken,
               resolve_mispredict, flush,
        input  pred_ready, spec_hist, commit_hist, inflight, resolve_err
    );

    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_taken,
               resolve_mispredict, flush,
        output pred_ready, spec_hist, commit_hist, inflight, resolve_err
    );
`endif

endinterface
`default_nettype wire

// File: rtl/spec_ghr_shiftreg_ckpt_fifo.sv
`default_nettype none
// =============================================================================
// Module      : ghr_ckpt_fifo
// Description : In-order circular buffer of pre-shift history checkpoints.
//               Occupancy is a counter, pointers wrap modulo DEPTH.
// Ports       : CLK, RST (async, active-high), i_push, i_pop, i_clear,
//               i_push_data, o_head_data (oldest entry), o_count.
// Revision    : 1.0 - initial release
// =============================================================================
module ghr_ckpt_fifo
    import ghr_pkg::*;
#(
    parameter int WIDTH = GHR_HIST_LEN_DEF,
    parameter int DEPTH = GHR_CKPT_DEPTH_DEF
) (
    input  wire logic                           CLK,
    input  wire logic                           RST,
    input  wire logic                           i_push,
    input  wire logic                           i_pop,
    input  wire logic                           i_clear,
    input  wire logic [WIDTH-1:0]               i_push_data,
    output logic      [WIDTH-1:0]               o_head_data,
    output logic      [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge CLK) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/spec_ghr_shiftreg.sv
`default_nettype none
// =============================================================================
// Module      : spec_ghr_shiftreg
// Description : Speculative global-history shift register. Predicted
//               directions shift in at fetch with the pre-shift history
//               checkpointed; resolves update a committed copy; a mispredict
//               repairs from the oldest checkpoint, a flush restores from the
//               committed copy. Priority: flush > mispredict > predict.
// Ports       : CLK, RST (async, active-high), bus (spec_ghr_shiftreg_if.slave)
// Options     : SPEC_GHR_STATS_EN adds a saturating 16-bit mispredict counter.
// Revision    : 1.0 - initial release
// =============================================================================
module spec_ghr_shiftreg
    import ghr_pkg::*;
#(
    parameter int HIST_LEN   = GHR_HIST_LEN_DEF,    // 2..GHR_HIST_MAX
    parameter int CKPT_DEPTH = GHR_CKPT_DEPTH_DEF   // power of two, >= 2
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    spec_ghr_shiftreg_if.slave    bus
);

    localparam int CNT_W = $clog2(CKPT_DEPTH+1);

    logic [HIST_LEN-1:0] r_spec_hist;
    logic [HIST_LEN-1:0] r_commit_hist;
    logic                r_resolve_err;

    logic [HIST_LEN-1:0] w_fifo_head;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_pred_ready;
    logic                w_pred_acc;
    logic                w_res_ok;
    logic                w_misp;
    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_fifo_clear;
    ghr_prio_e           w_prio;
    logic [HIST_LEN-1:0] w_commit_next;
    logic [HIST_LEN-1:0] w_spec_next;
    logic [HIST_LEN-1:0] w_spec_shift;
    logic [HIST_LEN-1:0] w_repair_hist;

    // Ready depends on stored occupancy only, never on a same-cycle resolve.
    assign w_pred_ready = (w_fifo_count != CNT_W'(CKPT_DEPTH));
    assign w_pred_acc   = bus.pred_valid && w_pred_ready;
    assign w_res_ok     = bus.resolve_valid && (w_fifo_count != '0);
    assign w_misp       = w_res_ok && bus.resolve_mispredict;

    assign w_spec_shift  = HIST_LEN'(shift_in(GHR_HIST_MAX'(r_spec_hist), bus.pred_taken));
    assign w_repair_hist = HIST_LEN'(shift_in(GHR_HIST_MAX'(w_fifo_head), bus.resolve_taken));

    always_comb begin
        w_commit_next = r_commit_hist;
        if (w_res_ok) begin
            w_commit_next = HIST_LEN'(shift_in(GHR_HIST_MAX'(r_commit_hist), bus.resolve_taken));
        end
    end

    always_comb begin
        w_prio = PRIO_NONE;
        if (bus.flush) begin
            w_prio = PRIO_FLUSH;
        end else if (w_misp) begin
            w_prio = PRIO_MISP;
        end else if (w_pred_acc) begin
            w_prio = PRIO_PRED;
        end
    end

    // Flush restores the committed value including this cycle's resolve.
    always_comb begin
        w_spec_next = r_spec_hist;
        case (w_prio)
            PRIO_FLUSH: w_spec_next = w_commit_next;
            PRIO_MISP:  w_spec_next = w_repair_hist;
            PRIO_PRED:  w_spec_next = w_spec_shift;
            default:    w_spec_next = r_spec_hist;
        endcase
    end

    // A squashing event empties the FIFO, so pop only matters otherwise.
    assign w_fifo_clear = bus.flush || w_misp;
    assign w_fifo_push  = (w_prio == PRIO_PRED);
    assign w_fifo_pop   = w_res_ok && !w_fifo_clear;

    ghr_ckpt_fifo #(
        .WIDTH (HIST_LEN),
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .i_push      (w_fifo_push),
        .i_pop       (w_fifo_pop),
        .i_clear     (w_fifo_clear),
        .i_push_data (r_spec_hist),
        .o_head_data (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_spec_hist   <= '0;
            r_commit_hist <= '0;
            r_resolve_err <= 1'b0;
        end else begin
            r_spec_hist   <= w_spec_next;
            r_commit_hist <= w_commit_next;
            if (bus.resolve_valid && (w_fifo_count == '0)) begin
                r_resolve_err <= 1'b1;
            end
        end
    end

`ifdef SPEC_GHR_STATS_EN
    logic [15:0] r_mispredict_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mispredict_cnt <= '0;
        end else if (w_misp && (r_mispredict_cnt != 16'hFFFF)) begin
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
        end
    end

    assign bus.mispredict_cnt = r_mispredict_cnt;
`endif

    assign bus.pred_ready  = w_pred_ready;
    assign bus.spec_hist   = r_spec_hist;
    assign bus.commit_hist = r_commit_hist;
    assign bus.inflight    = w_fifo_count;
    assign bus.resolve_err = r_resolve_err;

endmodule
`default_nettype wire

// File: doc/spec_ghr_shiftreg.md
Name: spec_ghr_shiftreg

Overview:
- Parametrised speculative global-history shift register for the branch predictor front end.
- Shifts predicted directions in at fetch, and checkpoints pre-shift history in an in-order FIFO.
- Keeps an architectural (committed) copy updated at branch resolution.
- On mispredict, repairs speculative history from the oldest checkpoint plus the actual outcome. On a pipeline flush, it restores from the committed copy.

Parameters:
- HIST_LEN, 8, history bits (≥2).
- CKPT_DEPTH, 4, maximum in-flight unresolved branches (power of two, ≥2).

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- pred_valid  in  1  fetch predicts a conditional branch this cycle.
- pred_taken  in  1  predicted direction.
- pred_ready  out  1  checkpoint slot available.
- resolve_valid  in  1  oldest in-flight branch resolves.
- resolve_taken  in  1  actual direction.
- resolve_mispredict  in  1  actual direction differs from predicted.
- flush  in  1  pipeline flush (exception/redirect not from a branch).
- spec_hist  out  HIST_LEN  speculative history, newest bit at [0].
- commit_hist  out  HIST_LEN  committed history, newest bit at [0].
- inflight  out  $clog2(CKPT_DEPTH+1)  checkpoint occupancy.
- resolve_err  out  1  sticky: resolve seen with FIFO empty.

Behaviour:
- Reset (async, RST=1): spec_hist=0, commit_hist=0, inflight=0, FIFO pointers=0, resolve_err=0, pred_ready=1.
- pred_ready = (inflight != CKPT_DEPTH); combinational from state only. It does not depend on same-cycle resolve.
- Predict accept (pred_valid & pred_ready):
  - Push current spec_hist into the FIFO.
  - Next-cycle spec_hist = {spec_hist[HIST_LEN-2:0], pred_taken}.
  - One-cycle latency.
- pred_valid while not ready: ignored, no state change. The upstream must hold.
- Resolve (resolve_valid, inflight>0):
  - Pop the oldest entry.
  - commit_hist = {commit_hist[HIST_LEN-2:0], resolve_taken}.
- Resolve with resolve_mispredict:
  - spec_hist = {popped_ckpt[HIST_LEN-2:0], resolve_taken}.
  - All younger checkpoints discarded; inflight=0, pointers reset.
  - A same-cycle predict is squashed (wrong path): no push, no shift.
- Resolve without mispredict plus same-cycle accepted predict:
  - Push and pop both occur; inflight unchanged.
  - spec_hist shifts with pred_taken.
- Resolve with inflight==0: no pop, commit_hist unchanged, resolve_err set until RST.
- Flush:
  - Highest priority.
  - spec_hist = commit_hist (the value after any same-cycle resolve update).
  - FIFO emptied; same-cycle predict dropped.
- Priority: flush > mispredict > predict.
- Pointer wrap is modulo CKPT_DEPTH. Occupancy is tracked by a count, not by pointer compare.
- Outputs are registered; no combinational path from inputs to spec_hist, commit_hist or inflight.

Optional Feature:
- Macro: SPEC_GHR_STATS_EN.
- Defined:
  - Adds output mispredict_cnt [15:0], reset 0.
  - Increments on each resolve with resolve_mispredict and inflight>0.
  - Saturates at 16'hFFFF; cleared only by RST.
- Undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Shared package ghr_pkg:
  - GHR_HIST_LEN_DEF=8, GHR_CKPT_DEPTH_DEF=4.
  - Function shift_in(hist, bit) used by both history registers.
  - Typedef ghr_prio_e {PRIO_NONE, PRIO_PRED, PRIO_MISP, PRIO_FLUSH} for the next-state select.
- One sub-module, ghr_ckpt_fifo:
  - Parametrised circular buffer (width HIST_LEN, depth CKPT_DEPTH).
  - push, pop, clear, head data, count.
- History muxing stays in the top.

Test Plan:
- Reset then 3 predicts T,N,T, no resolve → spec_hist=8'b0000_0101, inflight=3, commit_hist=0.
- Fill: 4 predicts → pred_ready=0. 5th pred_valid held → no change. Resolve correct T → inflight stays 4 that cycle, pred_ready=1 next cycle.
- Mispredict:
  - Predicts T,T,T from spec_hist=0.
  - Resolve oldest mispredict, actual N → spec_hist=8'b0000_0000, commit_hist=0, inflight=0.
  - A simultaneous pred_valid is not shifted in.
- Correct resolve + predict same cycle:
  - inflight=2; resolve T, predict N → inflight=2, commit_hist LSB=1, spec_hist LSB=0.
- Flush with inflight=3, commit_hist=8'h0B, same-cycle correct resolve N → commit_hist=8'h16, spec_hist=8'h16, inflight=0.
- Resolve on empty → resolve_err=1 and held. Async RST pulse mid-cycle clears it and all state immediately. With SPEC_GHR_STATS_EN, 2 mispredicts → mispredict_cnt=2.
